// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage.
// Holds the PC and fetches one 32-bit word at a time from instruction memory
// over a req/gnt/rvalid handshake, then presents it to decode under a
// valid/ready handshake. A redirect retargets the PC and discards wrong-path
// work.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   imem_req, imem_addr      fetch request / word-aligned address
//   imem_gnt                 memory accepts the request this cycle
//   imem_rvalid, imem_rdata  fetch response
//   redirect_valid/_pc       control-flow redirect (target low bits forced to 0)
//   inst_ready               decode consumes the held instruction
//   inst_valid, inst,
//   inst_pc, inst_pcplus4    instruction presented to decode
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RESET | held in reset; leaves on the first cycle with rst low
// S_FETCH | request pc, waiting for a grant
// S_WAIT  | one request outstanding, waiting for its response
// S_VALID | instruction held and presented to decode
module inst_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            inst_ready,
   output logic            inst_valid,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pcplus4
);

   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_VALID = 2'd3;

   logic [1:0]      state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] inst_pc_q;
   logic [31:0]     inst_q;
   logic            discard;
   logic [XLEN-1:0] redirect_tgt;
   logic [1:0]      unused_redirect_low;

   assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_low = redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RESET;
         pc        <= RESET_PC;
         inst_pc_q <= RESET_PC;
         inst_q    <= NOP_INST;
         discard   <= 1'b0;
      end else begin
         case (state)
            S_RESET: state <= S_FETCH;
            S_FETCH: begin
               if (redirect_valid) pc <= redirect_tgt;
               if (imem_gnt) begin
                  state   <= S_WAIT;
                  // a grant taken alongside a redirect fetched the old path
                  discard <= redirect_valid;
               end
            end
            S_WAIT: begin
               if (redirect_valid) pc <= redirect_tgt;
               if (imem_rvalid) begin
                  discard <= 1'b0;
                  if (!discard && !redirect_valid) begin
                     inst_q    <= imem_rdata;
                     inst_pc_q <= pc;
                     state     <= S_VALID;
                  end else begin
                     state <= S_FETCH;
                  end
               end else if (redirect_valid) begin
                  discard <= 1'b1;
               end
            end
            S_VALID: begin
               if (redirect_valid) begin
                  pc    <= redirect_tgt;
                  state <= S_FETCH;
               end else if (inst_ready) begin
                  pc    <= pc + XLEN'(4);
                  state <= S_FETCH;
               end
            end
            default: state <= S_RESET;
         endcase
      end
   end

   assign imem_req     = (state == S_FETCH);
   assign imem_addr    = pc;
   assign inst_valid   = (state == S_VALID);
   assign inst         = inst_valid ? inst_q : NOP_INST;
   assign inst_pc      = inst_pc_q;
   assign inst_pcplus4 = inst_pc_q + XLEN'(4);

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the RISC-V core: holds the PC and fetches one 32-bit instruction at a time from instruction memory over a request/grant/response handshake. It presents each instruction, with its PC and PC+4, to the decode stage under a valid/ready handshake. Decode takes the opcode from `inst[6:0]`. Branch and JAL resolution drives the redirect port, which retargets the PC and discards wrong-path work.

## Interface
- `XLEN`, 32, address and PC width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; low 2 bits must be 0.
- `NOP_INST`, 32'h0000_0013, value driven on `inst` while no instruction is held (`addi x0,x0,0`).

- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request; a transfer occurs only on a cycle with `imem_req & imem_gnt`.
- `imem_addr` out XLEN: fetch address, always word aligned.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in 32: fetched instruction word.
- `redirect_valid` in 1: control-flow redirect (taken branch or JAL).
- `redirect_pc` in XLEN: redirect target; bits [1:0] are ignored and forced to 0.
- `inst_ready` in 1: decode consumes the held instruction this cycle.
- `inst_valid` out 1: `inst`, `inst_pc` and `inst_pcplus4` are valid.
- `inst` out 32: held instruction.
- `inst_pc` out XLEN: address of `inst`.
- `inst_pcplus4` out XLEN: `inst_pc + 4`, the JAL link value.

## Operation
- **Registers:**
  - `pc` (XLEN), the next address to fetch.
  - `state` (2 bits).
  - `discard` (1 bit).
  - Instruction and PC holding registers.
- **FSM states:**
  - **RESET:** entered only while `rst` is high. Leaves to FETCH on the first cycle with `rst` low.
  - **FETCH:**
    - `imem_req=1`, `imem_addr=pc`.
    - If `imem_gnt`, go to WAIT.
    - If no grant, stay in FETCH. An ungranted request carries no commitment, so `imem_addr` may change on a redirect.
  - **WAIT:**
    - Exactly one request is outstanding; `imem_req=0`.
    - On `imem_rvalid` with `discard=0`: latch `imem_rdata` into `inst` and `pc` into `inst_pc`, then go to VALID.
    - On `imem_rvalid` with `discard=1`: drop the data, clear `discard`, go to FETCH.
  - **VALID:**
    - `inst_valid=1`, `imem_req=0`.
    - On `inst_ready`: `pc <= pc+4`, go to FETCH.
- **Redirect (highest priority, any state except RESET):** `pc <= {redirect_pc[XLEN-1:2],2'b00}`, and in addition:
  - FETCH without grant: stay in FETCH.
  - FETCH with `imem_gnt` in the same cycle: the granted request is wrong-path. Go to WAIT with `discard=1`.
  - WAIT without `imem_rvalid`: set `discard=1` and stay in WAIT.
  - WAIT with `imem_rvalid` in the same cycle: drop the data and go to FETCH; `discard` stays 0.
  - VALID: drop the held instruction and go to FETCH. `inst_ready` in the same cycle is ignored.
- **Other rules:**
  - `imem_rvalid` is ignored outside WAIT.
  - `pc+4` and `inst_pcplus4` wrap modulo 2^XLEN.
  - `imem_req`, `inst_valid` and all data outputs are functions of registered state only. There is no combinational input-to-output path.
- **Reset mid-operation:** everything returns to its reset value and any outstanding request is abandoned. Instruction memory is reset by the same `rst`, so no stale response follows.

## Timing
- **Reset values:**
  - `imem_req=0`, `imem_addr=RESET_PC`.
  - `inst_valid=0`, `inst=NOP_INST`.
  - `inst_pc=RESET_PC`, `inst_pcplus4=RESET_PC+4`.
  - `discard=0`, state RESET.
- **First request:** `imem_req=1` in the first cycle after `rst` falls.
- **Best-case sequence:** T0 FETCH (grant), T1 WAIT (`rvalid`), T2 VALID with `inst_valid=1`. With `inst_ready` at T2, the next request is at T3. Best-case throughput is 1 instruction per 3 cycles.
- **Memory latency:** any response latency ≥1 cycle after the grant is tolerated. Grant may be delayed indefinitely.
- **Redirect latency:** a redirect in cycle T makes the next FETCH at T+1 use the target address. A redirect does not itself produce a bubble beyond a discarded response.
- **Held outputs:** `inst`, `inst_pc` and `inst_pcplus4` are stable while `inst_valid=1 & !inst_ready & !redirect_valid`.

## Test plan
- **Reset and sequential fetch:**
  - Stimulus: `rst` for 2 cycles; memory returns 0x00500093, 0x00a00113, 0x002081b3 at 0x0, 0x4, 0x8; grant the same cycle; `rvalid` 1 cycle after the grant; `inst_ready` held 1.
  - Required: `imem_addr` steps 0x0, 0x4, 0x8; `inst_valid` every 3rd cycle carrying matching `inst`/`inst_pc`; `inst_pcplus4` 0x4, 0x8, 0xC.
- **Backpressure and delayed grant:**
  - Stimulus: hold `inst_ready=0` for 5 cycles in VALID; delay `imem_gnt` by 4 cycles.
  - Required: outputs frozen; `imem_req` stays 1 with a constant `imem_addr`; no extra fetch issued.
- **Redirect during WAIT:**
  - Stimulus: `redirect_valid` with `redirect_pc=0x100` one cycle before `rvalid` for address 0x8.
  - Required: the 0x8 data is never presented; the next request is to 0x100; the first valid `inst_pc` is 0x100.
- **Redirect collisions:**
  - Stimulus: redirect in the same cycle as a grant; redirect in the same cycle as `rvalid`; redirect together with `inst_ready` in VALID; `redirect_pc=0x103`.
  - Required: each case yields the next valid `inst_pc=0x100` with no wrong-path instruction.
- **Wrap and reset mid-fetch:**
  - Stimulus: `RESET_PC=0xFFFFFFFC`; then assert `rst` while in WAIT.
  - Required: the second fetch address is 0x0; `inst_pcplus4` for the first instruction is 0x0; after the mid-fetch reset, outputs take their reset values and fetch restarts at `RESET_PC`.
